// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA timing generator. Produces horizontal and
//               vertical sync, a display-enable flag, a fetch request that
//               runs RD_LEAD pixels ahead of the beam, line/frame start
//               pulses and an 8-bit frame counter. Counters advance only on
//               clocks where both en_i and pix_en_i are high, so one clk can
//               serve several pixel rates.
// Optional    : VGA_DOUBLE_EN - when defined, req_x_o/req_y_o address a
//               half-resolution frame buffer (each stored pixel covers a 2x2
//               block of screen pixels). req_valid_o is unaffected.
// Ports       : clk           system clock
//               rst           asynchronous reset, active-high
//               en_i          timing enable; low holds the counters at origin
//               pix_en_i      pixel tick
//               h_sync_o      horizontal sync (active level HS_POL)
//               v_sync_o      vertical sync (active level VS_POL)
//               disp_o        beam inside the active area
//               req_valid_o   req_x_o/req_y_o address a pixel to fetch
//               req_x_o       fetch column (0 when req_valid_o is low)
//               req_y_o       fetch row (0 when req_valid_o is low)
//               line_start_o  one-clk pulse when h_cnt loads 0
//               frame_start_o one-clk pulse when (h_cnt,v_cnt) loads (0,0)
//               frame_cnt_o   frame counter, +1 per frame_start_o, wraps
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int RD_LEAD = 2,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           pix_en_i,
    output logic           h_sync_o,
    output logic           v_sync_o,
    output logic           disp_o,
    output logic           req_valid_o,
    output logic [X_W-1:0] req_x_o,
    output logic [Y_W-1:0] req_y_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic [7:0]     frame_cnt_o
);

    // ------------------------------------------------------------------------
    // Derived timing values
    // ------------------------------------------------------------------------
    localparam int H_TOT = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int H_ST  = H_SYNC + H_BP;
    localparam int H_END = H_ST + H_DISP;
    localparam int V_TOT = V_SYNC + V_BP + V_DISP + V_FP;
    localparam int V_ST  = V_SYNC + V_BP;
    localparam int V_END = V_ST + V_DISP;

    // Counter widths hold the full total so that an end boundary equal to the
    // total (zero front porch) is still representable.
    localparam int HC_W = $clog2(H_TOT + 1);
    localparam int VC_W = $clog2(V_TOT + 1);
    // The lead-adjusted column can exceed H_TOT-1; one extra bit keeps it
    // from wrapping back into the visible range.
    localparam int HX_W = HC_W + 1;

    localparam logic [HC_W-1:0] H_TOT_M1  = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0] H_SYNC_C  = HC_W'(H_SYNC);
    localparam logic [HX_W-1:0] H_ST_X    = HX_W'(H_ST);
    localparam logic [HX_W-1:0] H_END_X   = HX_W'(H_END);
    localparam logic [HX_W-1:0] RD_LEAD_X = HX_W'(RD_LEAD);
    localparam logic [VC_W-1:0] V_TOT_M1  = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0] V_SYNC_C  = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] V_ST_C    = VC_W'(V_ST);
    localparam logic [VC_W-1:0] V_END_C   = VC_W'(V_END);
    localparam logic            HS_ACT    = 1'(HS_POL);
    localparam logic            VS_ACT    = 1'(VS_POL);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [HC_W-1:0] h_cnt_q,       h_cnt_d;
    logic [VC_W-1:0] v_cnt_q,       v_cnt_d;
    logic            run_q,         run_d;
    logic            h_sync_q,      h_sync_d;
    logic            v_sync_q,      v_sync_d;
    logic            disp_q,        disp_d;
    logic            req_valid_q,   req_valid_d;
    logic [X_W-1:0]  req_x_q,       req_x_d;
    logic [Y_W-1:0]  req_y_q,       req_y_d;
    logic            line_start_q,  line_start_d;
    logic            frame_start_q, frame_start_d;
    logic [7:0]      frame_cnt_q,   frame_cnt_d;

    // ------------------------------------------------------------------------
    // Position the counters would load on a tick
    // ------------------------------------------------------------------------
    logic [HC_W-1:0] w_h_nxt;
    logic [VC_W-1:0] w_v_nxt;
    logic [HX_W-1:0] w_hx;
    logic [HX_W-1:0] w_rx_full;
    logic [VC_W-1:0] w_ry_full;
    logic            w_h_act;
    logic            w_v_act;
    logic            w_req_h_act;
    logic [X_W-1:0]  w_rx;
    logic [Y_W-1:0]  w_ry;

    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        // run_q low means the counters sit at origin but (0,0) has not been
        // presented yet: the first tick loads (0,0) rather than (1,0) so that
        // the first line and frame start are announced with pulses.
        if (run_q) begin
            if (h_cnt_q == H_TOT_M1) begin
                w_h_nxt = '0;
                if (v_cnt_q == V_TOT_M1) begin
                    w_v_nxt = '0;
                end else begin
                    w_v_nxt = v_cnt_q + 1'b1;
                end
            end else begin
                w_h_nxt = h_cnt_q + 1'b1;
                w_v_nxt = v_cnt_q;
            end
        end
    end

    always_comb begin
        // Lead position is not reduced modulo H_TOT, so requests never wrap
        // into the next line.
        w_hx        = {1'b0, w_h_nxt} + RD_LEAD_X;
        w_h_act     = ({1'b0, w_h_nxt} >= H_ST_X) && ({1'b0, w_h_nxt} < H_END_X);
        w_v_act     = (w_v_nxt >= V_ST_C) && (w_v_nxt < V_END_C);
        w_req_h_act = (w_hx >= H_ST_X) && (w_hx < H_END_X);
        w_rx_full   = w_hx - H_ST_X;
        w_ry_full   = w_v_nxt - V_ST_C;
`ifdef VGA_DOUBLE_EN
        w_rx        = X_W'(w_rx_full >> 1);
        w_ry        = Y_W'(w_ry_full >> 1);
`else
        w_rx        = X_W'(w_rx_full);
        w_ry        = Y_W'(w_ry_full);
`endif
    end

    // ------------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------------
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        run_d         = run_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        disp_d        = disp_q;
        req_valid_d   = req_valid_q;
        req_x_d       = req_x_q;
        req_y_d       = req_y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (!en_i) begin
            h_cnt_d     = '0;
            v_cnt_d     = '0;
            run_d       = 1'b0;
            h_sync_d    = ~HS_ACT;
            v_sync_d    = ~VS_ACT;
            disp_d      = 1'b0;
            req_valid_d = 1'b0;
            req_x_d     = '0;
            req_y_d     = '0;
        end else if (pix_en_i) begin
            h_cnt_d       = w_h_nxt;
            v_cnt_d       = w_v_nxt;
            run_d         = 1'b1;
            h_sync_d      = (w_h_nxt < H_SYNC_C) ? HS_ACT : ~HS_ACT;
            v_sync_d      = (w_v_nxt < V_SYNC_C) ? VS_ACT : ~VS_ACT;
            disp_d        = w_h_act && w_v_act;
            req_valid_d   = w_req_h_act && w_v_act;
            req_x_d       = (w_req_h_act && w_v_act) ? w_rx : '0;
            req_y_d       = (w_req_h_act && w_v_act) ? w_ry : '0;
            line_start_d  = (w_h_nxt == '0);
            frame_start_d = (w_h_nxt == '0) && (w_v_nxt == '0);
            if ((w_h_nxt == '0) && (w_v_nxt == '0)) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            run_q         <= 1'b0;
            h_sync_q      <= ~HS_ACT;
            v_sync_q      <= ~VS_ACT;
            disp_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            run_q         <= run_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            disp_q        <= disp_d;
            req_valid_q   <= req_valid_d;
            req_x_q       <= req_x_d;
            req_y_q       <= req_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign h_sync_o      = h_sync_q;
    assign v_sync_o      = v_sync_q;
    assign disp_o        = disp_q;
    assign req_valid_o   = req_valid_q;
    assign req_x_o       = req_x_q;
    assign req_y_o       = req_y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

`default_nettype wire
